// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared definitions for the register file slice:
//   - default word and address widths
//   - derived default register count
//   - clear-sequencer state encoding
// -----------------------------------------------------------------------------
package reg_file_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;
    localparam int DEF_NREG   = 2 ** DEF_ADDR_W;

    // Sequencer state. IDLE accepts writes and bypasses; CLEARING walks the
    // index from 0 to NREG-1, zeroing one word per cycle.
    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } clr_state_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_word.sv
// -----------------------------------------------------------------------------
// reg_word
// One DATA_W-bit storage word built from edge-triggered bits, with a
// synchronous active-high reset and a load enable.
// Ports:
//   clk   in   1       clock, rising edge
//   srst  in   1       synchronous reset, active-high, forces q to zero
//   load  in   1       capture d on the next rising edge
//   d     in   DATA_W  data to capture
//   q     out  DATA_W  stored value
// -----------------------------------------------------------------------------
module reg_word
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule : reg_word

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// Small register file for the CPU datapath: one synchronous write port, two
// combinational read ports with write-to-read bypass, and a sequenced clear
// that zeroes one word per cycle.
// Ports:
//   CLK   in   1       clock, all state updates on the rising edge
//   RST   in   1       synchronous active-high reset, highest priority
//   WE    in   1       write enable (honoured in IDLE only)
//   WA    in   ADDR_W  write address
//   WD    in   DATA_W  write data
//   RA1   in   ADDR_W  read address, port 1
//   RD1   out  DATA_W  read data, port 1 (combinational)
//   RA2   in   ADDR_W  read address, port 2
//   RD2   out  DATA_W  read data, port 2 (combinational)
//   CLR   in   1       start a clear sequence (ignored while one is running)
//   BUSY  out  1       high in every cycle of the clear sequence
// -----------------------------------------------------------------------------
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WA,
    input  logic [DATA_W-1:0] WD,
    input  logic [ADDR_W-1:0] RA1,
    output logic [DATA_W-1:0] RD1,
    input  logic [ADDR_W-1:0] RA2,
    output logic [DATA_W-1:0] RD2,
    input  logic              CLR,
    output logic              BUSY
);

    localparam int NREG = 2 ** ADDR_W;

    clr_state_t        state_reg;
    clr_state_t        state_next;
    logic [ADDR_W-1:0] idx_reg;
    logic [ADDR_W-1:0] idx_next;

    logic              clearing;
    logic [DATA_W-1:0] wr_data;
    logic [NREG-1:0]   word_load;
    logic [DATA_W-1:0] word_q [NREG];

    logic              bypass1;
    logic              bypass2;

    // -------------------------------------------------------------------------
    // Clear sequencer: state and index registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                idx_next = '0;
                if (CLR) begin
                    state_next = CLEARING;
                end
            end
            CLEARING: begin
                // Index wraps naturally back to 0 as the last word is cleared.
                idx_next = idx_reg + ADDR_W'(1);
                if (&idx_reg) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    assign clearing = (state_reg == CLEARING);
    assign BUSY     = clearing;

    // During a clear every word load carries zero; otherwise it carries WD.
    assign wr_data = clearing ? '0 : WD;

    // -------------------------------------------------------------------------
    // Storage: one reg_word per register, each with its own decoded enable.
    // A CLR arriving with WE in IDLE still performs the write on that edge;
    // the sequence then overwrites it when the index reaches WA.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_word
            assign word_load[gi] = clearing ? (idx_reg == ADDR_W'(gi))
                                            : (WE && (WA == ADDR_W'(gi)));

            reg_word #(
                .DATA_W (DATA_W)
            ) u_word (
                .clk  (CLK),
                .srst (RST),
                .load (word_load[gi]),
                .d    (wr_data),
                .q    (word_q[gi])
            );
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Read ports. Bypass forwards the in-flight write only in IDLE; during a
    // clear the writes are dropped, so forwarding them would show data that
    // never reaches storage.
    // -------------------------------------------------------------------------
    assign bypass1 = !clearing && WE && (WA == RA1);
    assign bypass2 = !clearing && WE && (WA == RA2);

    assign RD1 = bypass1 ? WD : word_q[RA1];
    assign RD2 = bypass2 ? WD : word_q[RA2];

endmodule : reg_file
